// File: rtl/bikelight_array.sv
// N_CH-channel bike light: per-channel 2-flop sync, debounce and 4-mode FSM sharing blink/PWM timebases.
// Mode advances DEBOUNCE_CYC+2 edges after a clean button rise; LED follows one cycle later; no backpressure.
module bikelight_array #(
   parameter int N_CH         = 2,
   parameter int DEBOUNCE_CYC = 16,
   parameter int BLINK_HALF   = 8,
   parameter int PWM_BITS     = 4,
   parameter int DIM_DUTY     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   btn,
   output logic [N_CH-1:0]   led,
   output logic [2*N_CH-1:0] mode,
   output logic [N_CH-1:0]   press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [BLK_W-1:0]  BLK_LAST = BLK_W'(BLINK_HALF - 1);
   localparam logic [PWM_BITS:0] DUTY     = (PWM_BITS + 1)'(DIM_DUTY);

   typedef enum logic [1:0] {
      M_OFF   = 2'b00,
      M_ON    = 2'b01,
      M_BLINK = 2'b10,
      M_DIM   = 2'b11
   } mode_t;

   logic [BLK_W-1:0]    r_blink_cnt;
   logic                r_blink_phase;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic                w_pwm_on;

   // Shared timebases run freely from reset; mode changes never restart them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
         r_pwm_cnt     <= '0;
      end else begin
         if (r_blink_cnt == BLK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + BLK_W'(1);
         end
         r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      end
   end

   // Extra MSB lets DIM_DUTY == 2**PWM_BITS mean always on.
   assign w_pwm_on = ({1'b0, r_pwm_cnt} < DUTY);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic             r_sync_a;
      logic             r_sync_b;
      logic             r_stable;
      logic             r_stable_d;
      logic [CNT_W-1:0] r_cnt;
      logic             r_press;
      logic             r_led;
      mode_t            r_mode;
      mode_t            w_mode_nxt;
      logic             w_rise;
      logic             w_led_nxt;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_sync_a   <= 1'b0;
            r_sync_b   <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
         end else begin
            r_sync_a   <= btn[g];
            r_sync_b   <= r_sync_a;
            r_stable_d <= r_stable;
            if (r_sync_b == r_stable) begin
               r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
               r_stable <= r_sync_b;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end

      assign w_rise = r_stable & ~r_stable_d;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_mode  <= M_OFF;
            r_press <= 1'b0;
            r_led   <= 1'b0;
         end else begin
            r_mode  <= w_mode_nxt;
            r_press <= w_rise;
            r_led   <= w_led_nxt;
         end
      end

      always_comb begin
         w_mode_nxt = r_mode;
         w_led_nxt  = 1'b0;
         if (w_rise) begin
            case (r_mode)
               M_OFF:   w_mode_nxt = M_ON;
               M_ON:    w_mode_nxt = M_BLINK;
               M_BLINK: w_mode_nxt = M_DIM;
               M_DIM:   w_mode_nxt = M_OFF;
               default: w_mode_nxt = M_OFF;
            endcase
         end
         case (r_mode)
            M_OFF:   w_led_nxt = 1'b0;
            M_ON:    w_led_nxt = 1'b1;
            M_BLINK: w_led_nxt = r_blink_phase;
            M_DIM:   w_led_nxt = w_pwm_on;
            default: w_led_nxt = 1'b0;
         endcase
      end

      assign led[g]        = r_led;
      assign press[g]      = r_press;
      assign mode[2*g +: 2] = r_mode;
   end

endmodule

// File: tb/tb_bikelight_array.sv
// Randomised bench for bikelight_array against a history-based reference model.
module tb_bikelight_array;

   localparam int N     = 2;
   localparam int DC    = 4;
   localparam int BH    = 3;
   localparam int PB    = 3;
   localparam int DUTY  = 2;
   localparam int MAXC  = 8192;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   btn = '0;
   logic [N-1:0]   led;
   logic [2*N-1:0] mode;
   logic [N-1:0]   press;

   bikelight_array #(
      .N_CH(N), .DEBOUNCE_CYC(DC), .BLINK_HALF(BH), .PWM_BITS(PB), .DIM_DUTY(DUTY)
   ) dut (
      .clk(clk), .reset(reset), .btn(btn), .led(led), .mode(mode), .press(press)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errs    = 0;

   // Model: n = edges since reset release; b_at = button sampled at each edge,
   // s_at = debounced level, md_at = channel modes after each edge.
   int             n;
   logic [N-1:0]   b_at  [MAXC];
   logic [N-1:0]   s_at  [MAXC];
   logic [2*N-1:0] md_at [MAXC];
   logic [N-1:0]   exp_led;
   logic [N-1:0]   exp_press;
   logic [2*N-1:0] exp_mode;

   function automatic logic [N-1:0] bget(int j);
      return (j < 1) ? '0 : b_at[j];
   endfunction

   function automatic logic [N-1:0] sget(int j);
      return (j < 0) ? '0 : s_at[j];
   endfunction

   // Light level for a mode, with the timebases as they stood after k edges.
   function automatic logic light(logic [1:0] m, int k);
      logic phase, pwm_on;
      phase  = (((k / BH) % 2) == 0);
      pwm_on = ((k % (1 << PB)) < DUTY);
      case (m)
         2'd0:    return 1'b0;
         2'd1:    return 1'b1;
         2'd2:    return phase;
         default: return pwm_on;
      endcase
   endfunction

   task automatic model_clear();
      n         = 0;
      s_at[0]   = '0;
      md_at[0]  = '0;
      exp_led   = '0;
      exp_press = '0;
      exp_mode  = '0;
   endtask

   task automatic model_step();
      logic [N-1:0]   s1, s2, bj, snew, p;
      logic [2*N-1:0] mnew;
      logic [1:0]     m_prev;
      logic           acc;
      n = n + 1;
      if (n >= MAXC) begin
         $display("FAIL model_capacity edges %0d limit %0d", n, MAXC);
         $fatal(1);
      end
      b_at[n] = btn;
      s1 = sget(n - 1);
      s2 = sget(n - 2);
      snew = s1;
      p    = '0;
      mnew = '0;
      for (int c = 0; c < N; c++) begin
         // Accept a new level only after DC consecutive synchronised samples disagree.
         acc = 1'b1;
         for (int j = n - DC + 1; j <= n; j++) begin
            bj = bget(j - 2);
            if (j < 1 || bj[c] == s1[c]) acc = 1'b0;
         end
         if (acc) snew[c] = ~s1[c];
         p[c] = s1[c] & ~s2[c];
         m_prev = md_at[n-1][2*c +: 2];
         mnew[2*c +: 2] = m_prev + {1'b0, p[c]};
         exp_led[c] = light(m_prev, n - 1);
      end
      s_at[n]   = snew;
      md_at[n]  = mnew;
      exp_mode  = mnew;
      exp_press = p;
   endtask

   task automatic tick(input logic [N-1:0] b);
      btn = b;
      @(posedge clk);
      if (!reset) model_step();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_clear();
      for (int k = 0; k < 8; k++) begin
         tick(N'($urandom));
         vectors++;
         if ({press, mode, led} !== {exp_press, exp_mode, exp_led}) begin
            errs++;
            $display("FAIL reset_hold cyc %0d got p=%b m=%b l=%b want p=%b m=%b l=%b",
                     k, press, mode, led, exp_press, exp_mode, exp_led);
         end
      end
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick('0);
         vectors++;
         if ({press, mode, led} !== {exp_press, exp_mode, exp_led}) begin
            errs++;
            $display("FAIL reset_release cyc %0d got p=%b m=%b l=%b want p=%b m=%b l=%b",
                     k, press, mode, led, exp_press, exp_mode, exp_led);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [1:0] start;
      int         seen, npress;
      start  = mode[1:0];
      seen   = -1;
      npress = 0;
      for (int k = 0; k < 20; k++) begin
         tick(2'b01);
         vectors++;
         if ({press, mode, led} !== {exp_press, exp_mode, exp_led}) begin
            errs++;
            $display("FAIL clean_press cyc %0d got p=%b m=%b l=%b want p=%b m=%b l=%b",
                     k, press, mode, led, exp_press, exp_mode, exp_led);
         end
         if (press[0]) npress++;
         if (seen < 0 && mode[1:0] != start) seen = k;
      end
      vectors++;
      if (seen !== DC + 2) begin
         errs++;
         $display("FAIL press_latency got %0d edges want %0d", seen, DC + 2);
      end
      vectors++;
      if (npress !== 1) begin
         errs++;
         $display("FAIL press_count_held got %0d want 1", npress);
      end
      for (int k = 0; k < DC + 4; k++) begin
         tick('0);
         vectors++;
         if ({press, mode, led} !== {exp_press, exp_mode, exp_led}) begin
            errs++;
            $display("FAIL clean_release cyc %0d got p=%b m=%b l=%b want p=%b m=%b l=%b",
                     k, press, mode, led, exp_press, exp_mode, exp_led);
         end
      end
   endtask

   task automatic test_glitch();
      int len;
      logic [N-1:0] pat [$];
      len = $urandom_range(1, DC - 1);
      for (int k = 0; k < len; k++) pat.push_back(2'b01);
      for (int k = 0; k < 10; k++) pat.push_back(2'b00);
      for (int k = 0; k < DC + 6; k++) pat.push_back(2'b01);
      len = $urandom_range(1, DC - 1);
      for (int k = 0; k < len; k++) pat.push_back(2'b00);
      for (int k = 0; k < 10; k++) pat.push_back(2'b01);
      for (int k = 0; k < DC + 6; k++) pat.push_back(2'b00);
      foreach (pat[k]) begin
         tick(pat[k]);
         vectors++;
         if ({press, mode, led} !== {exp_press, exp_mode, exp_led}) begin
            errs++;
            $display("FAIL glitch step %0d got p=%b m=%b l=%b want p=%b m=%b l=%b",
                     k, press, mode, led, exp_press, exp_mode, exp_led);
         end
      end
   endtask

   task automatic test_mode_cycle();
      logic [1:0] start, want_m;
      int         ones, win, want_ones;
      start = mode[1:0];
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < DC + 3; k++) begin
            tick(2'b01);
            vectors++;
            if ({press, mode, led} !== {exp_press, exp_mode, exp_led}) begin
               errs++;
               $display("FAIL cycle_press %0d cyc %0d got p=%b m=%b l=%b want p=%b m=%b l=%b",
                        i, k, press, mode, led, exp_press, exp_mode, exp_led);
            end
         end
         for (int k = 0; k < int'($urandom_range(DC + 3, DC + 9)); k++) begin
            tick('0);
            vectors++;
            if ({press, mode, led} !== {exp_press, exp_mode, exp_led}) begin
               errs++;
               $display("FAIL cycle_idle %0d cyc %0d got p=%b m=%b l=%b want p=%b m=%b l=%b",
                        i, k, press, mode, led, exp_press, exp_mode, exp_led);
            end
         end
         want_m = start + 2'(i + 1);
         vectors++;
         if (mode[1:0] !== want_m) begin
            errs++;
            $display("FAIL cycle_mode %0d got %b want %b", i, mode[1:0], want_m);
         end
         win = (want_m == 2'd2) ? 4 * BH : (1 << (PB + 1));
         want_ones = (want_m == 2'd0) ? 0 : (want_m == 2'd1) ? win :
                     (want_m == 2'd2) ? win / 2 : 2 * DUTY;
         ones = 0;
         for (int k = 0; k < win; k++) begin
            tick('0);
            if (led[0]) ones++;
         end
         vectors++;
         if (ones !== want_ones) begin
            errs++;
            $display("FAIL led_duty mode %b got %0d lit of %0d want %0d", want_m, ones, win, want_ones);
         end
      end
   endtask

   task automatic test_simultaneous();
      int both;
      both = 0;
      for (int k = 0; k < 2 * DC + 8; k++) begin
         tick((k < DC + 4) ? 2'b11 : 2'b00);
         vectors++;
         if ({press, mode, led} !== {exp_press, exp_mode, exp_led}) begin
            errs++;
            $display("FAIL simultaneous cyc %0d got p=%b m=%b l=%b want p=%b m=%b l=%b",
                     k, press, mode, led, exp_press, exp_mode, exp_led);
         end
         if (press == 2'b11) both++;
      end
      vectors++;
      if (both !== 1) begin
         errs++;
         $display("FAIL simultaneous_pulse got %0d joint pulses want 1", both);
      end
   endtask

   task automatic test_reset_mid();
      int late;
      for (int i = 0; i < 4 && exp_mode[3:2] != 2'd2; i++) begin
         for (int k = 0; k < 2 * DC + 5; k++) begin
            tick((k < DC + 3) ? 2'b10 : 2'b00);
            vectors++;
            if ({press, mode, led} !== {exp_press, exp_mode, exp_led}) begin
               errs++;
               $display("FAIL mid_setup cyc %0d got p=%b m=%b l=%b want p=%b m=%b l=%b",
                        k, press, mode, led, exp_press, exp_mode, exp_led);
            end
         end
      end
      for (int k = 0; k < 3; k++) tick(2'b01);
      #2;
      reset = 1'b1;
      model_clear();
      btn = '0;
      #1;
      vectors++;
      if ({press, mode, led} !== {exp_press, exp_mode, exp_led}) begin
         errs++;
         $display("FAIL reset_async got p=%b m=%b l=%b want p=%b m=%b l=%b",
                  press, mode, led, exp_press, exp_mode, exp_led);
      end
      tick('0);
      tick('0);
      reset = 1'b0;
      late = 0;
      for (int k = 0; k < 3 * DC; k++) begin
         tick('0);
         vectors++;
         if ({press, mode, led} !== {exp_press, exp_mode, exp_led}) begin
            errs++;
            $display("FAIL reset_after cyc %0d got p=%b m=%b l=%b want p=%b m=%b l=%b",
                     k, press, mode, led, exp_press, exp_mode, exp_led);
         end
         if (press != '0) late++;
      end
      vectors++;
      if (late !== 0) begin
         errs++;
         $display("FAIL pending_press got %0d pulses want 0", late);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] b;
      int           hold;
      for (int seg = 0; seg < 120; seg++) begin
         b    = N'($urandom);
         hold = $urandom_range(1, 2 * DC + 2);
         for (int k = 0; k < hold; k++) begin
            tick(b);
            vectors++;
            if ({press, mode, led} !== {exp_press, exp_mode, exp_led}) begin
               errs++;
               $display("FAIL random seg %0d cyc %0d got p=%b m=%b l=%b want p=%b m=%b l=%b",
                        seg, k, press, mode, led, exp_press, exp_mode, exp_led);
            end
         end
      end
   endtask

   initial begin
      model_clear();
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_clean_press();
      test_glitch();
      test_mode_cycle();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
